sync_fifo_ext: RTL and testbench

- Synchronous single-clock FIFO for peripheral buffering (UART TX/RX, SPI, GPIO event queues); successor to the existing 8-deep peripheral FIFO.
- Adds: any DEPTH (not only powers of two), all DEPTH entries usable, occupancy count, programmable almost-full/almost-empty flags, selectable show-ahead or registered read, flush, sticky overflow/underflow flags.

---
 rtl/sync_fifo_ext.sv | 155 +++++++++++++++
 tb/tb_sync_fifo_ext.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds, flush, sticky error flags and either show-ahead or registered read data.
module sync_fifo_ext #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit SHOW_AHEAD = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         read,
    output logic [WIDTH-1:0]             read_data,
    output logic                         read_valid,
    input  logic                         flush,
    input  logic                         clear_err,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          af_q,     af_d;
    logic          ae_q,     ae_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic          rd_ok;
    logic          wr_ok;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Flush suppresses both requests, so it also suppresses any error they would raise.
        rd_ok = read && !empty_q && !flush;
        wr_ok = write && (!full_q || rd_ok) && !flush;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (int'(count_d) >= AF_LEVEL);
        ae_d    = (int'(count_d) <= AE_LEVEL);

        // A new error in the same cycle as clear_err leaves the flag set.
        ovf_d = (ovf_q && !clear_err) || (write && !wr_ok && !flush);
        udf_d = (udf_q && !clear_err) || (read && empty_q && !flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_LEVEL <= 0);
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            assign read_data  = mem_q[rd_ptr_q];
            assign read_valid = !empty_q;
        end else begin : g_registered
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) begin
                        rdata_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign read_data  = rdata_q;
            assign read_valid = rvalid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: a show-ahead and a registered-read
// instance (DEPTH=5) share one stimulus stream.
module tb_sync_fifo_ext;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             write;
    logic [WIDTH-1:0] write_data;
    logic             read;
    logic             flush;
    logic             clear_err;

    logic [WIDTH-1:0] a_rdata, b_rdata;
    logic             a_rvalid, b_rvalid;
    logic             a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic             b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [CW-1:0]    a_count, b_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1), .SHOW_AHEAD(1'b1)
    ) u_sa (
        .clk(clk), .reset(reset), .write(write), .write_data(write_data),
        .read(read), .read_data(a_rdata), .read_valid(a_rvalid),
        .flush(flush), .clear_err(clear_err), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1), .SHOW_AHEAD(1'b0)
    ) u_reg (
        .clk(clk), .reset(reset), .write(write), .write_data(write_data),
        .read(read), .read_data(b_rdata), .read_valid(b_rvalid),
        .flush(flush), .clear_err(clear_err), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0; write_data = '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        write = 1'b1; write_data = d;
        tick();
        write = 1'b0;
    endtask

    task automatic pop();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_count", 32'(a_count), 0);
        check_eq("rst_empty", 32'(a_empty), 1);
        check_eq("rst_full",  32'(a_full),  0);
        check_eq("rst_ae",    32'(a_ae),    1);
        check_eq("rst_af",    32'(a_af),    0);
        check_eq("rst_ovf",   32'(a_ovf),   0);
        check_eq("rst_udf",   32'(a_udf),   0);
        check_eq("rst_rv_sa", 32'(a_rvalid), 0);
        check_eq("rst_rv_rg", 32'(b_rvalid), 0);
        check_eq("rst_rd_rg", 32'(b_rdata),  0);

        // Fill 0x11..0x15, watching count and thresholds
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(8'h11 + i));
            check_eq($sformatf("fill_count%0d", i), 32'(a_count), 32'(i + 1));
            check_eq($sformatf("fill_ae%0d", i),    32'(a_ae),    32'((i + 1) <= 1));
            check_eq($sformatf("fill_af%0d", i),    32'(a_af),    32'((i + 1) >= 4));
            check_eq($sformatf("fill_full%0d", i),  32'(a_full),  32'((i + 1) == 5));
        end

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            check_eq($sformatf("drain_data%0d", i), 32'(a_rdata), 32'(8'h11 + i));
            pop();
        end
        check_eq("drain_empty", 32'(a_empty), 1);
        check_eq("drain_count", 32'(a_count), 0);
        check_eq("drain_rv",    32'(a_rvalid), 0);

        // Overflow on a lone write when full, then clear_err
        for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
        push(8'h99);
        check_eq("ovf_set",   32'(a_ovf),   1);
        check_eq("ovf_count", 32'(a_count), 5);
        check_eq("ovf_head",  32'(a_rdata), 32'h11);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_eq("ovf_clear", 32'(a_ovf), 0);

        // Pass-through at full: write 0xAA with a read
        check_eq("pt_rd", 32'(a_rdata), 32'h11);
        write = 1'b1; write_data = 8'hAA; read = 1'b1;
        tick();
        idle_inputs();
        check_eq("pt_count", 32'(a_count), 5);
        check_eq("pt_ovf",   32'(a_ovf),   0);
        check_eq("pt_head",  32'(a_rdata), 32'h12);
        for (int i = 0; i < 4; i++) pop();
        check_eq("wrap_data",  32'(a_rdata), 32'hAA);
        check_eq("wrap_count", 32'(a_count), 1);
        pop();
        check_eq("wrap_empty", 32'(a_empty), 1);

        // Empty with simultaneous read+write
        write = 1'b1; write_data = 8'h3C; read = 1'b1;
        tick();
        idle_inputs();
        check_eq("er_udf",   32'(a_udf),   1);
        check_eq("er_count", 32'(a_count), 1);
        check_eq("er_data",  32'(a_rdata), 32'h3C);
        pop();
        // New underflow and clear_err together: set wins
        read = 1'b1; clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("udf_setwins", 32'(a_udf), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_eq("udf_clear", 32'(a_udf), 0);

        // Registered read path
        do_reset();
        push(8'h01);
        push(8'h02);
        check_eq("rg_rv_idle", 32'(b_rvalid), 0);
        read = 1'b1;
        tick();
        check_eq("rg_rv1",   32'(b_rvalid), 1);
        check_eq("rg_data1", 32'(b_rdata),  32'h01);
        tick();
        read = 1'b0;
        check_eq("rg_rv2",   32'(b_rvalid), 1);
        check_eq("rg_data2", 32'(b_rdata),  32'h02);
        tick();
        check_eq("rg_rv3",   32'(b_rvalid), 0);
        check_eq("rg_hold",  32'(b_rdata),  32'h02);
        check_eq("rg_empty", 32'(b_empty),  1);

        // Flush beats simultaneous write+read
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check_eq("fl_pre_count", 32'(a_count), 3);
        flush = 1'b1; write = 1'b1; write_data = 8'h77; read = 1'b1;
        tick();
        idle_inputs();
        check_eq("fl_count", 32'(a_count), 0);
        check_eq("fl_empty", 32'(a_empty), 1);
        check_eq("fl_ovf",   32'(a_ovf),   0);
        check_eq("fl_udf",   32'(a_udf),   0);
        check_eq("fl_rv_rg", 32'(b_rvalid), 0);
        push(8'h44);
        check_eq("fl_head",  32'(a_rdata), 32'h44);
        check_eq("fl_count1", 32'(a_count), 1);

        // Reset mid-burst with an error flag pending
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        check_eq("mb_ovf", 32'(a_ovf), 1);
        reset = 1'b1; write = 1'b1; write_data = 8'hEE; read = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        check_eq("mb_count", 32'(a_count), 0);
        check_eq("mb_empty", 32'(a_empty), 1);
        check_eq("mb_full",  32'(a_full),  0);
        check_eq("mb_ae",    32'(a_ae),    1);
        check_eq("mb_af",    32'(a_af),    0);
        check_eq("mb_ovf0",  32'(a_ovf),   0);
        check_eq("mb_udf0",  32'(a_udf),   0);
        check_eq("mb_rv_rg", 32'(b_rvalid), 0);
        check_eq("mb_rd_rg", 32'(b_rdata),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
